// File: rtl/coherence_pkg.sv
// Shared coherence types: bus request encodings, MOESI/L2 line formats and
// the snoop bus arbiter state enum.
package coherence_pkg;

  localparam int CPU_CORES      = 4;
  localparam int ADDR_BITS      = 10;
  localparam int OFFSET_BITS    = 4;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  typedef enum logic [2:0] {
    MOESI_I = 3'd0,
    MOESI_S = 3'd1,
    MOESI_E = 3'd2,
    MOESI_O = 3'd3,
    MOESI_M = 3'd4
  } moesi_t;

  typedef struct packed {
    moesi_t                    state;
    logic [LINE_ADDR_BITS-1:0] tag;
    logic [31:0]               data;
  } l1_cacheline_t;

  typedef enum logic [1:0] {
    L2_INVALID = 2'd0,
    L2_CLEAN   = 2'd1,
    L2_DIRTY   = 2'd2
  } l2_state_t;

  typedef struct packed {
    l2_state_t                 state;
    logic [CPU_CORES-1:0]      sharers;
    logic [LINE_ADDR_BITS-1:0] tag;
    logic [31:0]               data;
  } l2_cacheline_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    MEM   = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus bundle between the L1 controllers, the arbiter and the L2 port.
// master is the arbiter side; slave is the cores/L2 side.
interface snoop_bus_arbiter_if #(
  parameter int N_CORES = coherence_pkg::CPU_CORES,
  parameter int LADDR_W = coherence_pkg::LINE_ADDR_BITS,
  parameter int IDX_W   = $clog2(coherence_pkg::CPU_CORES)
) ();
  import coherence_pkg::*;

  logic [N_CORES-1:0]              req;
  logic [N_CORES-1:0][1:0]         req_type;
  logic [N_CORES-1:0][LADDR_W-1:0] req_addr;
  logic [N_CORES-1:0]              snoop_ack;
  logic [N_CORES-1:0]              snoop_shared;
  logic [N_CORES-1:0]              snoop_supply;
  logic                            l2_ack;

  logic [N_CORES-1:0]              grant;
  logic                            bus_valid;
  bus_req_t                        bus_type;
  logic [LADDR_W-1:0]              bus_addr;
  logic [IDX_W-1:0]                bus_src;
  logic                            bus_shared;
  logic                            l2_req;
  logic                            l2_write;
  logic                            txn_done;

  modport master (
    input  req, req_type, req_addr, snoop_ack, snoop_shared, snoop_supply, l2_ack,
    output grant, bus_valid, bus_type, bus_addr, bus_src, bus_shared,
           l2_req, l2_write, txn_done
  );

  modport slave (
    output req, req_type, req_addr, snoop_ack, snoop_shared, snoop_supply, l2_ack,
    input  grant, bus_valid, bus_type, bus_addr, bus_src, bus_shared,
           l2_req, l2_write, txn_done
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping around.
// Purely combinational so other arbiters can register around it as they need.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(rr_ptr) + i) % N;
      if (!any && req[pos]) begin
        any       = 1'b1;
        pick[pos] = 1'b1;
        idx       = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the snooping coherence bus: grants one core, broadcasts
// its request, gathers peer snoop responses and falls back to L2 when needed.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests from rr_ptr
// SNOOP | broadcast active, waiting for every peer snoop_ack
// MEM   | L2 access outstanding, waiting for l2_ack
// DONE  | txn_done pulse; grant and bus fields clear next cycle
module snoop_bus_arbiter
  import coherence_pkg::*;
#(
  parameter int N_CORES = CPU_CORES,
  parameter int LADDR_W = LINE_ADDR_BITS,
  parameter int IDX_W   = $clog2(CPU_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  snoop_bus_arbiter_if.master  bus
);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [N_CORES-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [N_CORES-1:0] grant_q;
  bus_req_t           type_q;
  logic [LADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]   src_q;
  logic               shared_q;

  logic               peers_acked;
  logic               peer_supply;
  logic               peer_shared;

  // grant_q is the one-hot source mask, so the source never blocks or routes itself
  assign peers_acked = &(bus.snoop_ack | grant_q);
  assign peer_supply = |(bus.snoop_supply & ~grant_q);
  assign peer_shared = |(bus.snoop_shared & ~grant_q);

  rr_priority_picker #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .pick   (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_any) state_nxt = SNOOP;
      SNOOP: begin
        if (peers_acked) begin
          case (type_q)
            BUS_UPGR: state_nxt = DONE;
            BUS_WB:   state_nxt = MEM;
            default:  state_nxt = peer_supply ? DONE : MEM;
          endcase
        end
      end
      MEM:   if (bus.l2_ack) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      type_q   <= BUS_RD;
      addr_q   <= '0;
      src_q    <= '0;
      shared_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_onehot;
            type_q   <= bus_req_t'(bus.req_type[pick_idx]);
            addr_q   <= bus.req_addr[pick_idx];
            src_q    <= pick_idx;
            shared_q <= 1'b0;
          end
        end
        SNOOP: if (peers_acked) shared_q <= peer_shared;
        DONE: begin
          grant_q  <= '0;
          type_q   <= BUS_RD;
          addr_q   <= '0;
          src_q    <= '0;
          shared_q <= 1'b0;
          rr_ptr   <= (src_q == IDX_W'(N_CORES - 1)) ? '0 : src_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.bus_valid  = (state == SNOOP);
  assign bus.bus_type   = type_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_src    = src_q;
  assign bus.bus_shared = shared_q;
  assign bus.l2_req     = (state == MEM);
  assign bus.l2_write   = (state == MEM) && (type_q == BUS_WB);
  assign bus.txn_done   = (state == DONE);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: one task per scenario, inputs driven
// and outputs sampled 1 time unit after each rising edge.
module tb_snoop_bus_arbiter;
  import coherence_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  snoop_bus_arbiter_if bif ();

  snoop_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.req          = '0;
    bif.req_type     = '0;
    bif.req_addr     = '0;
    bif.snoop_ack    = '0;
    bif.snoop_shared = '0;
    bif.snoop_supply = '0;
    bif.l2_ack       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    checks++; if (bif.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", bif.grant); end
    checks++; if (bif.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b want 0", bif.bus_valid); end
    checks++; if (bif.l2_req !== 1'b0) begin errors++; $display("FAIL reset_l2_req: got %b want 0", bif.l2_req); end
    checks++; if (bif.txn_done !== 1'b0) begin errors++; $display("FAIL reset_txn_done: got %b want 0", bif.txn_done); end
    checks++; if (bif.bus_type !== BUS_RD || bif.bus_addr !== 6'h00 || bif.bus_src !== 2'd0) begin
      errors++; $display("FAIL reset_bus_fields: got type %0d addr %h src %0d want 0 0 0", bif.bus_type, bif.bus_addr, bif.bus_src);
    end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
    reset = 1'b0;
  endtask

  task automatic test_single_rd();
    bif.req         = 4'b0100;
    bif.req_type[2] = BUS_RD;
    bif.req_addr[2] = 6'h15;
    step();
    checks++; if (bif.grant !== 4'b0100) begin errors++; $display("FAIL rd_grant: got %b want 0100", bif.grant); end
    checks++; if (bif.bus_valid !== 1'b1 || bif.bus_src !== 2'd2 || bif.bus_addr !== 6'h15 || bif.bus_type !== BUS_RD) begin
      errors++; $display("FAIL rd_broadcast: got valid %b src %0d addr %h type %0d want 1 2 15 0", bif.bus_valid, bif.bus_src, bif.bus_addr, bif.bus_type);
    end
    bif.req_addr[2] = 6'h3F;
    bif.req_type[2] = BUS_WB;
    bif.snoop_ack   = 4'b1011;
    step();
    bif.snoop_ack = 4'b0000;
    checks++; if (bif.l2_req !== 1'b1 || bif.l2_write !== 1'b0 || bif.bus_valid !== 1'b0) begin
      errors++; $display("FAIL rd_mem_entry: got l2_req %b l2_write %b valid %b want 1 0 0", bif.l2_req, bif.l2_write, bif.bus_valid);
    end
    checks++; if (bif.bus_addr !== 6'h15 || bif.bus_type !== BUS_RD) begin
      errors++; $display("FAIL rd_latched: got addr %h type %0d want 15 0", bif.bus_addr, bif.bus_type);
    end
    step();
    checks++; if (bif.l2_req !== 1'b1 || bif.txn_done !== 1'b0) begin
      errors++; $display("FAIL rd_mem_hold: got l2_req %b txn_done %b want 1 0", bif.l2_req, bif.txn_done);
    end
    bif.l2_ack = 1'b1;
    step();
    bif.l2_ack = 1'b0;
    bif.req    = 4'b0000;
    checks++; if (bif.txn_done !== 1'b1 || bif.l2_req !== 1'b0 || bif.grant !== 4'b0100) begin
      errors++; $display("FAIL rd_done: got txn_done %b l2_req %b grant %b want 1 0 0100", bif.txn_done, bif.l2_req, bif.grant);
    end
    step();
    checks++; if (bif.txn_done !== 1'b0 || bif.grant !== 4'b0000) begin
      errors++; $display("FAIL rd_release: got txn_done %b grant %b want 0 0000", bif.txn_done, bif.grant);
    end
    checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL rd_rr_ptr: got %0d want 3", dut.rr_ptr); end
  endtask

  task automatic test_round_robin();
    idle_inputs();
    do_reset();
    bif.req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      bif.req_type[c] = BUS_RD;
      bif.req_addr[c] = 6'(c + 8);
    end
    bif.snoop_ack = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << k;
      step();
      checks++; if (bif.grant !== exp_g || bif.bus_src !== 2'(k) || bif.bus_addr !== 6'(k + 8)) begin
        errors++; $display("FAIL rr_grant_%0d: got grant %b src %0d addr %h want %b %0d %h", k, bif.grant, bif.bus_src, bif.bus_addr, exp_g, k, 6'(k + 8));
      end
      step();
      checks++; if (bif.l2_req !== 1'b1 || bif.grant !== exp_g) begin
        errors++; $display("FAIL rr_mem_%0d: got l2_req %b grant %b want 1 %b", k, bif.l2_req, bif.grant, exp_g);
      end
      bif.l2_ack = 1'b1;
      step();
      bif.l2_ack = 1'b0;
      checks++; if (bif.txn_done !== 1'b1) begin errors++; $display("FAIL rr_done_%0d: got txn_done %b want 1", k, bif.txn_done); end
      bif.req[k] = 1'b0;
      step();
      checks++; if (bif.grant !== 4'b0000 || bif.txn_done !== 1'b0) begin
        errors++; $display("FAIL rr_idle_gap_%0d: got grant %b txn_done %b want 0000 0", k, bif.grant, bif.txn_done);
      end
    end
    idle_inputs();
  endtask

  task automatic test_rdx_supply();
    bif.req         = 4'b0010;
    bif.req_type[1] = BUS_RDX;
    bif.req_addr[1] = 6'h07;
    step();
    checks++; if (bif.grant !== 4'b0010 || bif.bus_type !== BUS_RDX) begin
      errors++; $display("FAIL rdx_grant: got grant %b type %0d want 0010 1", bif.grant, bif.bus_type);
    end
    bif.snoop_ack    = 4'b1101;
    bif.snoop_supply = 4'b1000;
    bif.snoop_shared = 4'b1000;
    step();
    checks++; if (bif.txn_done !== 1'b1 || bif.l2_req !== 1'b0 || bif.bus_valid !== 1'b0) begin
      errors++; $display("FAIL rdx_direct_done: got txn_done %b l2_req %b valid %b want 1 0 0", bif.txn_done, bif.l2_req, bif.bus_valid);
    end
    checks++; if (bif.bus_shared !== 1'b1) begin errors++; $display("FAIL rdx_shared: got %b want 1", bif.bus_shared); end
    idle_inputs();
    step();
    checks++; if (bif.txn_done !== 1'b0 || bif.grant !== 4'b0000 || bif.bus_shared !== 1'b0) begin
      errors++; $display("FAIL rdx_release: got txn_done %b grant %b shared %b want 0 0000 0", bif.txn_done, bif.grant, bif.bus_shared);
    end
  endtask

  task automatic test_upgr_stagger();
    bif.req         = 4'b0001;
    bif.req_type[0] = BUS_UPGR;
    bif.req_addr[0] = 6'h33;
    step();
    checks++; if (bif.grant !== 4'b0001) begin errors++; $display("FAIL upgr_grant: got %b want 0001", bif.grant); end
    bif.snoop_ack = 4'b0010;
    step();
    checks++; if (bif.bus_valid !== 1'b1) begin errors++; $display("FAIL upgr_hold_1: got valid %b want 1", bif.bus_valid); end
    step();
    checks++; if (bif.bus_valid !== 1'b1) begin errors++; $display("FAIL upgr_hold_2: got valid %b want 1", bif.bus_valid); end
    bif.snoop_ack = 4'b0110;
    step();
    checks++; if (bif.bus_valid !== 1'b1 || bif.txn_done !== 1'b0) begin
      errors++; $display("FAIL upgr_hold_3: got valid %b txn_done %b want 1 0", bif.bus_valid, bif.txn_done);
    end
    bif.snoop_ack = 4'b1110;
    step();
    checks++; if (bif.txn_done !== 1'b1 || bif.l2_req !== 1'b0 || bif.bus_valid !== 1'b0) begin
      errors++; $display("FAIL upgr_done: got txn_done %b l2_req %b valid %b want 1 0 0", bif.txn_done, bif.l2_req, bif.bus_valid);
    end
    idle_inputs();
    step();
    checks++; if (bif.grant !== 4'b0000 || dut.rr_ptr !== 2'd1) begin
      errors++; $display("FAIL upgr_release: got grant %b rr_ptr %0d want 0000 1", bif.grant, dut.rr_ptr);
    end
  endtask

  task automatic test_wb();
    bif.req         = 4'b1000;
    bif.req_type[3] = BUS_WB;
    bif.req_addr[3] = 6'h2A;
    step();
    checks++; if (bif.grant !== 4'b1000 || bif.bus_addr !== 6'h2A || bif.bus_type !== BUS_WB || bif.bus_src !== 2'd3) begin
      errors++; $display("FAIL wb_grant: got grant %b addr %h type %0d src %0d want 1000 2a 3 3", bif.grant, bif.bus_addr, bif.bus_type, bif.bus_src);
    end
    bif.snoop_ack    = 4'b0111;
    bif.snoop_supply = 4'b0010;
    bif.snoop_shared = 4'b1000;
    step();
    checks++; if (bif.l2_req !== 1'b1 || bif.l2_write !== 1'b1 || bif.txn_done !== 1'b0) begin
      errors++; $display("FAIL wb_mem: got l2_req %b l2_write %b txn_done %b want 1 1 0", bif.l2_req, bif.l2_write, bif.txn_done);
    end
    checks++; if (bif.bus_shared !== 1'b0) begin errors++; $display("FAIL wb_src_shared_masked: got %b want 0", bif.bus_shared); end
    bif.snoop_ack    = 4'b0000;
    bif.snoop_supply = 4'b0000;
    bif.snoop_shared = 4'b0000;
    step();
    checks++; if (bif.l2_req !== 1'b1 || bif.l2_write !== 1'b1) begin
      errors++; $display("FAIL wb_mem_hold: got l2_req %b l2_write %b want 1 1", bif.l2_req, bif.l2_write);
    end
    bif.l2_ack = 1'b1;
    step();
    bif.l2_ack = 1'b0;
    checks++; if (bif.txn_done !== 1'b1 || bif.l2_req !== 1'b0 || bif.l2_write !== 1'b0) begin
      errors++; $display("FAIL wb_done: got txn_done %b l2_req %b l2_write %b want 1 0 0", bif.txn_done, bif.l2_req, bif.l2_write);
    end
    idle_inputs();
    step();
    checks++; if (bif.grant !== 4'b0000 || dut.rr_ptr !== 2'd0) begin
      errors++; $display("FAIL wb_release: got grant %b rr_ptr %0d want 0000 0", bif.grant, dut.rr_ptr);
    end
  endtask

  task automatic test_reset_mid_txn();
    idle_inputs();
    do_reset();
    bif.req         = 4'b0100;
    bif.req_type[2] = BUS_RD;
    bif.req_addr[2] = 6'h11;
    step();
    bif.snoop_ack = 4'b1011;
    step();
    bif.snoop_ack = 4'b0000;
    checks++; if (bif.l2_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got l2_req %b want 1", bif.l2_req); end
    reset = 1'b1;
    step();
    checks++; if (bif.grant !== 4'b0000 || bif.l2_req !== 1'b0 || bif.txn_done !== 1'b0 || bif.bus_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got grant %b l2_req %b txn_done %b valid %b want 0000 0 0 0", bif.grant, bif.l2_req, bif.txn_done, bif.bus_valid);
    end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL rst_mid_rr_ptr: got %0d want 0", dut.rr_ptr); end
    reset = 1'b0;
    idle_inputs();
    bif.req         = 4'b1010;
    bif.req_type[1] = BUS_RD;
    bif.req_type[3] = BUS_RD;
    step();
    checks++; if (bif.grant !== 4'b0010 || bif.txn_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_regrant: got grant %b txn_done %b want 0010 0", bif.grant, bif.txn_done);
    end
    bif.snoop_ack    = 4'b1101;
    bif.snoop_supply = 4'b0001;
    step();
    checks++; if (bif.txn_done !== 1'b1 || bif.l2_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_supplied: got txn_done %b l2_req %b want 1 0", bif.txn_done, bif.l2_req);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_rd();
    test_round_robin();
    test_rdx_supply();
    test_upgr_stagger();
    test_wb();
    test_reset_mid_txn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shares the single snooping coherence bus between the `CPU_CORES` L1 cache controllers.
- Arbitrates requests round-robin and broadcasts the winning transaction to all snoopers.
- Collects snoop acknowledges and shared/owner responses, and sequences the L2 access when no peer supplies data.
- Sits between the per-core L1 controllers (which drive each L1 array's snoop port) and the L2.

Parameters:
- N_CORES, 4, number of requesters; equals `CPU_CORES`.
- LADDR_W, 6, line address width; `ADDR_BITS - OFFSET_BITS`.
- IDX_W, 2, requester index width; clog2(N_CORES).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_CORES  per-core bus request; held until txn_done for that core.
- req_type  in  N_CORES x 2  per-core bus_req_t (BUS_RD/BUS_RDX/BUS_UPGR/BUS_WB).
- req_addr  in  N_CORES x LADDR_W  per-core line address.
- snoop_ack  in  N_CORES  per-core snooper finished the current broadcast.
- snoop_shared  in  N_CORES  snooper holds the line valid after the snoop.
- snoop_supply  in  N_CORES  snooper (O/M/E owner) supplies data.
- l2_ack  in  1  L2 completed the access (one-cycle pulse).
- grant  out  N_CORES  one-hot grant, held for the whole transaction.
- bus_valid  out  1  broadcast phase active.
- bus_type  out  2  latched bus_req_t of the winner.
- bus_addr  out  LADDR_W  latched winner address.
- bus_src  out  IDX_W  winner index; that core's snooper ignores the broadcast.
- bus_shared  out  1  OR of snoop_shared over non-source cores, latched at end of SNOOP.
- l2_req  out  1  L2 access request, level-held until l2_ack.
- l2_write  out  1  1 for BUS_WB, else 0; valid while l2_req.
- txn_done  out  1  one-cycle completion pulse to the granted core.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0. All outputs 0 on the cycle after reset is sampled. A reset mid-transaction aborts it; no txn_done is issued.
- FSM states: IDLE, SNOOP, MEM, DONE.
- IDLE:
  - If any req is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Latch type, addr and src; assert grant and bus_valid next cycle; go to SNOOP.
  - Latency from req to grant is 1 cycle.
- SNOOP:
  - bus_valid=1.
  - Wait until snoop_ack is set for every core except bus_src; the source's ack is a don't-care.
  - On completion, latch bus_shared and supplied = OR(snoop_supply & ~src mask), drop bus_valid, then:
    - BUS_UPGR → DONE.
    - BUS_WB → MEM.
    - BUS_RD or BUS_RDX with supplied=1 → DONE.
    - Otherwise → MEM.
  - Minimum SNOOP duration is 1 cycle.
- MEM: l2_req=1, l2_write per type. On l2_ack, go to DONE and deassert l2_req the same cycle the state leaves.
- DONE:
  - txn_done=1 for exactly 1 cycle.
  - grant and bus outputs clear on the following cycle.
  - rr_ptr = bus_src+1 (mod N_CORES); go to IDLE.
- After DONE there is at least one IDLE cycle before the next grant. A request arriving in DONE is arbitrated in IDLE with the updated pointer.
- req deasserted mid-transaction: ignored; the transaction completes normally.
- req_type and req_addr changes after the grant cycle are ignored (latched values are used).
- Multiple simultaneous requests: exactly one grant; grant is always one-hot or zero.
- BUS_UPGR whose snoop finds another UPGR race is resolved by snoopers, not by the arbiter.
- snoop_supply while the type is BUS_WB or BUS_UPGR: ignored for routing.
- bus_shared is valid from leaving SNOOP until the grant drops.

Decomposition:
- Shared package `coherence_pkg`:
  - bus_req_t, moesi_t, l1_cacheline_t, l2_state_t, l2_cacheline_t.
  - `ADDR_BITS`/`OFFSET_BITS`/`CPU_CORES` constants.
  - New arb_state_t enum {IDLE, SNOOP, MEM, DONE}.
- Sub-module `rr_priority_picker`: combinational, takes req, rr_ptr → one-hot pick, index, any. It is reused by the future L2 port arbiter.

Test Plan:
- Single BUS_RD from core 2, addr 0x15, no supplier: grant=0100 at t+1, bus_src=2, all peer acks at t+2, l2_req at t+3, l2_ack at t+5 → txn_done at t+6, l2_write=0, rr_ptr=3.
- All four cores request BUS_RD together with rr_ptr=0 and 1-cycle snoops/L2: grant order 0,1,2,3; each grant one-hot; never two grants in the same cycle.
- BUS_RDX from core 1, core 3 asserts snoop_supply and snoop_shared: no l2_req, go straight to DONE, bus_shared=1, txn_done 1 cycle.
- BUS_UPGR from core 0; peer acks staggered at +1, +3, +4 cycles → SNOOP holds until the last ack; no L2 access.
- BUS_WB from core 3, addr 0x2A: l2_req=1 with l2_write=1 until l2_ack; snoop_supply from core 1 ignored.
- Reset asserted during MEM: the next cycle has grant=0, l2_req=0, no txn_done, rr_ptr=0; a request from core 1 after reset is granted first.
